// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_default_data_width = 8;
    localparam int c_default_fifo_depth = 16;
    localparam int c_baud_div_width     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Host-side bus of the UART transmitter (FIFO, config, line).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int FIFO_DEPTH = c_default_fifo_depth
) ();

    logic [DATA_WIDTH-1:0]          write_data;
    logic                           write_en;
    logic                           fifo_clear;
    logic [c_baud_div_width-1:0]    baud_div;
    logic                           tx_enable;
    logic                           parity_en;
    logic                           parity_odd;
    logic                           two_stop;
    logic                           tx;
    logic                           tx_busy;
    logic                           tx_done;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           fifo_almost_empty;
    logic                           overflow;
    logic [$clog2(FIFO_DEPTH):0]    data_count;

    modport master (
        output write_data, write_en, fifo_clear, baud_div, tx_enable,
               parity_en, parity_odd, two_stop,
        input  tx, tx_busy, tx_done, fifo_empty, fifo_full,
               fifo_almost_empty, overflow, data_count
    );

    modport slave (
        input  write_data, write_en, fifo_clear, baud_div, tx_enable,
               parity_en, parity_odd, two_stop,
        output tx, tx_busy, tx_done, fifo_empty, fifo_full,
               fifo_almost_empty, overflow, data_count
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit FIFO with first-word fall-through read and status.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH             = 8,
    parameter int FIFO_DEPTH             = 16,
    parameter int ALMOST_EMPTY_THRESHOLD = 4,
    localparam int PTR_W                 = $clog2(FIFO_DEPTH),
    localparam int CNT_W                 = PTR_W + 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clear,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  rd_en,
    output logic      [DATA_WIDTH-1:0] rd_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic      [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write then.
    assign w_pop   = rd_en && !w_empty && !clear;
    assign w_push  = wr_en && !clear && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (wr_en && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data      = r_mem[r_rd_ptr];
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CNT_W'(ALMOST_EMPTY_THRESHOLD));
    assign overflow     = r_overflow;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : FIFO-fed UART transmitter with optional parity and 1/2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH             = c_default_data_width,
    parameter int FIFO_DEPTH             = c_default_fifo_depth,
    parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    uart_tx_if.slave  bus
);

    localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_WIDTH - 1);

    tx_state_t                   r_state;
    tx_state_t                   w_state_next;
    logic [DATA_WIDTH-1:0]       r_shift;
    logic [DATA_WIDTH-1:0]       w_shift_next;
    logic [DATA_WIDTH-1:0]       w_fifo_rdata;
    logic [c_baud_div_width-1:0] r_div;
    logic [c_baud_div_width-1:0] r_baud_cnt;
    logic [c_baud_div_width-1:0] w_baud_next;
    logic [c_bit_w-1:0]          r_bit_cnt;
    logic [c_bit_w-1:0]          w_bit_next;
    logic                        r_par_en;
    logic                        r_two_stop;
    logic                        r_par_bit;
    logic                        r_tx;
    logic                        w_tx_next;
    logic                        w_fifo_empty;
    logic                        w_pop;
    logic                        w_done;
    logic                        w_bit_end;
    logic                        w_can_start;

    uart_tx_fifo #(
        .DATA_WIDTH             (DATA_WIDTH),
        .FIFO_DEPTH             (FIFO_DEPTH),
        .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (bus.fifo_clear),
        .wr_en        (bus.write_en),
        .wr_data      (bus.write_data),
        .rd_en        (w_pop),
        .rd_data      (w_fifo_rdata),
        .empty        (w_fifo_empty),
        .full         (bus.fifo_full),
        .almost_empty (bus.fifo_almost_empty),
        .overflow     (bus.overflow),
        .count        (bus.data_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt + c_baud_div_width'(1);
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        w_tx_next    = 1'b1;
        w_bit_end    = (r_baud_cnt == r_div - c_baud_div_width'(1));
        // A flush in the same cycle cancels the pop, so no frame may start then.
        w_can_start  = bus.tx_enable && !w_fifo_empty && !bus.fifo_clear;

        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (w_can_start) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_bit_next   = '0;
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_cnt == c_bit_w'(r_two_stop)) begin
                        w_done     = 1'b1;
                        w_bit_next = '0;
                        if (w_can_start) begin
                            w_pop        = 1'b1;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_pop) begin
            w_shift_next = w_fifo_rdata;
        end

        // The line is registered, so it is driven from the level of the upcoming cycle.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_par_bit;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_div      <= c_baud_div_width'(1);
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx       <= w_tx_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            if (w_pop) begin
                r_div      <= (bus.baud_div < c_baud_div_width'(2)) ?
                              c_baud_div_width'(1) : bus.baud_div;
                r_par_en   <= bus.parity_en;
                r_two_stop <= bus.two_stop;
                r_par_bit  <= (^w_fifo_rdata) ^ bus.parity_odd;
            end
        end
    end

    assign bus.tx         = r_tx;
    assign bus.tx_busy    = (r_state != IDLE);
    assign bus.tx_done    = w_done;
    assign bus.fifo_empty = w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AE_THR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_if ();

    uart_tx #(
        .DATA_WIDTH             (DW),
        .FIFO_DEPTH             (DEPTH),
        .ALMOST_EMPTY_THRESHOLD (AE_THR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte queue plus the list of line levels of the frame in flight.
    logic [DW-1:0] m_q[$];
    bit            m_bits[$];
    bit            m_ovf  = 1'b0;
    bit            m_busy = 1'b0;
    int            m_div  = 1;
    int            m_cyc  = 0;
    bit            armed  = 1'b0;
    int            cyc_num = 0;
    int            done_cyc[$];

    always @(posedge clk) begin
        bit            ending;
        bit            can;
        logic [DW-1:0] b;
        cyc_num++;
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            m_cyc  = 0;
        end else begin
            ending = m_busy && (m_cyc == m_bits.size() * m_div - 1);
            can    = u_if.tx_enable && (m_q.size() > 0) && !u_if.fifo_clear;
            if (m_busy) m_cyc++;
            if (ending) m_busy = 1'b0;
            if (!m_busy && can) begin
                b = m_q.pop_front();
                m_bits.delete();
                m_bits.push_back(1'b0);
                for (int i = 0; i < DW; i++) m_bits.push_back(b[i]);
                if (u_if.parity_en) m_bits.push_back((^b) ^ u_if.parity_odd);
                m_bits.push_back(1'b1);
                if (u_if.two_stop) m_bits.push_back(1'b1);
                m_div  = (u_if.baud_div < 2) ? 1 : int'(u_if.baud_div);
                m_cyc  = 0;
                m_busy = 1'b1;
            end
            if (u_if.fifo_clear) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else if (u_if.write_en) begin
                if (m_q.size() < DEPTH) m_q.push_back(u_if.write_data);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_tx;
        bit exp_done;
        if (armed) begin
            exp_tx   = m_busy ? m_bits[m_cyc / m_div] : 1'b1;
            exp_done = m_busy && (m_cyc == m_bits.size() * m_div - 1);
            chk("tx",           32'(u_if.tx),                32'(exp_tx));
            chk("tx_busy",      32'(u_if.tx_busy),           32'(m_busy));
            chk("tx_done",      32'(u_if.tx_done),           32'(exp_done));
            chk("data_count",   32'(u_if.data_count),        32'(m_q.size()));
            chk("fifo_empty",   32'(u_if.fifo_empty),        32'(m_q.size() == 0));
            chk("fifo_full",    32'(u_if.fifo_full),         32'(m_q.size() == DEPTH));
            chk("almost_empty", 32'(u_if.fifo_almost_empty), 32'(m_q.size() <= AE_THR));
            chk("overflow",     32'(u_if.overflow),          32'(m_ovf));
            if (u_if.tx_done === 1'b1) done_cyc.push_back(cyc_num);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int baud, input bit pen, input bit podd, input bit two);
        u_if.baud_div   = 16'(baud);
        u_if.parity_en  = pen;
        u_if.parity_odd = podd;
        u_if.two_stop   = two;
    endtask

    task automatic push(input logic [DW-1:0] d);
        u_if.write_en   = 1'b1;
        u_if.write_data = d;
        tick();
        u_if.write_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((u_if.fifo_empty !== 1'b1 || u_if.tx_busy !== 1'b0) && k < 5000) begin
            tick();
            k++;
        end
        chk("idle_timeout", 32'(k < 5000), 32'd1);
    endtask

    initial begin
        int n0;
        int gap;
        u_if.write_en   = 1'b0;
        u_if.write_data = '0;
        u_if.fifo_clear = 1'b0;
        u_if.tx_enable  = 1'b0;
        cfg(4, 1'b0, 1'b0, 1'b0);
        tick(2);
        armed = 1'b1;
        tick(2);
        rst_n = 1'b1;

        // 0xA5 frames: plain, even parity, odd parity, odd parity with two stops
        u_if.tx_enable = 1'b1;
        n0 = done_cyc.size();
        push(8'hA5);
        wait_idle();
        chk("a5_done_pulses", 32'(done_cyc.size() - n0), 32'd1);
        cfg(4, 1'b1, 1'b0, 1'b0); push(8'hA5); wait_idle();
        cfg(4, 1'b1, 1'b1, 1'b0); push(8'hA5); wait_idle();
        cfg(4, 1'b1, 1'b1, 1'b1); push(8'hA5); wait_idle();

        // fill past capacity while disabled, then drain
        u_if.tx_enable = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("fill_count",    32'(u_if.data_count), 32'd16);
        chk("fill_full",     32'(u_if.fifo_full),  32'd1);
        chk("fill_overflow", 32'(u_if.overflow),   32'd1);
        cfg(2, 1'b0, 1'b0, 1'b0);
        u_if.tx_enable = 1'b1;
        wait_idle();

        // back-to-back frames
        u_if.tx_enable = 1'b0;
        push(8'h55);
        push(8'h0F);
        n0 = done_cyc.size();
        u_if.tx_enable = 1'b1;
        wait_idle();
        gap = (done_cyc.size() >= n0 + 2) ? done_cyc[n0+1] - done_cyc[n0] : -1;
        chk("b2b_pulses", 32'(done_cyc.size() - n0), 32'd2);
        chk("b2b_gap",    32'(gap),                  32'd20);

        // flush during the data bits of the first frame
        u_if.tx_enable = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        n0 = done_cyc.size();
        u_if.tx_enable = 1'b1;
        tick(5);
        u_if.fifo_clear = 1'b1;
        tick();
        u_if.fifo_clear = 1'b0;
        wait_idle();
        chk("clear_pulses",   32'(done_cyc.size() - n0), 32'd1);
        chk("clear_count",    32'(u_if.data_count),      32'd0);
        chk("clear_overflow", 32'(u_if.overflow),        32'd0);

        // reset in the middle of a frame
        u_if.tx_enable = 1'b0;
        cfg(4, 1'b0, 1'b0, 1'b0);
        push(8'h00);
        push(8'h00);
        u_if.tx_enable = 1'b1;
        tick(8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n0 = done_cyc.size();
        chk("rst_tx",    32'(u_if.tx),         32'd1);
        chk("rst_busy",  32'(u_if.tx_busy),    32'd0);
        chk("rst_count", 32'(u_if.data_count), 32'd0);
        tick(50);
        chk("rst_no_done", 32'(done_cyc.size() - n0), 32'd0);

        // randomized traffic with config churn, enable toggles, flushes and resets
        for (int c = 0; c < 5000; c++) begin
            u_if.write_en   = ($urandom_range(0, 5) == 0);
            u_if.write_data = 8'($urandom);
            if ($urandom_range(0, 30) == 0) begin
                cfg(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 60) == 0) u_if.tx_enable = ~u_if.tx_enable;
            u_if.fifo_clear = ($urandom_range(0, 300) == 0);
            rst_n           = ($urandom_range(0, 1500) != 0);
            tick();
        end
        u_if.write_en   = 1'b0;
        u_if.fifo_clear = 1'b0;
        u_if.tx_enable  = 1'b1;
        rst_n           = 1'b1;
        wait_idle();
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data bits per frame; FIFO_DEPTH, default 16, TX FIFO entries (power of 2); ALMOST_EMPTY_THRESHOLD, default 4, low-water mark.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 write_data  input  DATA_WIDTH  byte to enqueue.
REQ-005 write_en  input  1  enqueue strobe, one entry per high cycle.
REQ-006 fifo_clear  input  1  synchronous FIFO flush.
REQ-007 baud_div  input  16  clk cycles per serial bit.
REQ-008 tx_enable  input  1  permits starting new frames.
REQ-009 parity_en  input  1  insert parity bit.
REQ-010 parity_odd  input  1  1 = odd parity, 0 = even.
REQ-011 two_stop  input  1  1 = two stop bits, 0 = one.
REQ-012 tx  output  1  serial line, registered, idle high.
REQ-013 tx_busy  output  1  high in any state other than IDLE.
REQ-014 tx_done  output  1  one-cycle pulse at end of each frame's last stop bit.
REQ-015 fifo_empty, fifo_full, fifo_almost_empty  output  1 each  FIFO status; almost_empty = data_count <= ALMOST_EMPTY_THRESHOLD.
REQ-016 overflow  output  1  sticky, write attempted while full.
REQ-017 data_count  output  $clog2(FIFO_DEPTH)+1  entries held.

Function
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE, when tx_enable=1 and fifo_empty=0: pop one entry into a shift register, latch baud_div, parity_en, parity_odd, two_stop; state=START next cycle.
REQ-020 Each bit SHALL last exactly latched baud_div cycles; baud_div of 0 or 1 SHALL be treated as 1.
REQ-021 START drives tx=0; DATA drives DATA_WIDTH bits LSB first; PARITY (only if parity_en) drives XOR(data)^parity_odd; STOP drives tx=1 for 1 or 2 bit periods.
REQ-022 tx SHALL change only at bit-period boundaries; frame length = (1+DATA_WIDTH+parity_en+1+two_stop) x baud_div cycles.
REQ-023 On the last cycle of STOP, tx_done=1; if tx_enable=1 and FIFO non-empty, pop and go to START next cycle (no idle gap), else go to IDLE.
REQ-024 Configuration inputs changing mid-frame SHALL NOT affect the current frame.
REQ-025 tx_enable deassert mid-frame: current frame completes; no new frame starts.
REQ-026 Write while full and no pop that cycle: data dropped, count unchanged, overflow set.
REQ-027 Simultaneous write and pop: both succeed, count unchanged, including when full or when count=1.
REQ-028 Write while empty: entry not poppable until the following cycle.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 fifo_clear: pointers and count zeroed, overflow cleared, same-cycle write and pop ignored; an in-flight frame completes from the shift register.

Reset
REQ-031 With rst_n=0 at a clock edge: state=IDLE, tx=1, tx_busy=0, tx_done=0, data_count=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, overflow=0, pointers=0.
REQ-032 Reset mid-frame SHALL abort the frame; tx=1 from the next cycle.

Structure
REQ-033 Package uart_pkg SHALL hold the tx_state_t enum and default width/depth constants shared with the receive path.
REQ-034 FIFO SHALL be sub-module uart_tx_fifo (write/pop, clear, flags, overflow, count); FSM and shifter live in uart_tx.

Verification
REQ-035 baud_div=4, no parity, 1 stop, write 8'hA5, tx_enable=1 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; 40-cycle frame; one tx_done pulse.
REQ-036 Same byte, parity_en=1: parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; two_stop=1 -> frame 48 cycles.
REQ-037 tx_enable=0, write 17 bytes 0..16 -> data_count=16, fifo_full=1, overflow=1; enable -> bytes 0..15 sent in order, 16 never sent.
REQ-038 Queue 8'h55, 8'h0F, baud_div=2 -> second START immediately follows first STOP, two tx_done pulses 20 cycles apart, fifo_empty=1 after second pop.
REQ-039 Queue 5 bytes, fifo_clear during first frame's DATA -> first frame completes intact, count=0, overflow=0, no further frames.
REQ-040 rst_n=0 during DATA of 8'h00 -> next cycle tx=1, tx_busy=0, data_count=0, tx_done never pulses.
